// File: rtl/odd_parity_receiver_if.sv
// Serial receive bus: strobed line input and decoded frame results.
interface odd_parity_receiver_if #(
   parameter int unsigned ERR_CNT_W = 8
);
   localparam int unsigned DATA_W = 4;

   logic                  i_bit_en;
   logic                  i_rx;
   logic [DATA_W-1:0]     o_data;
   logic                  o_valid;
   logic                  o_parity_err;
   logic                  o_frame_err;
   logic [ERR_CNT_W-1:0]  o_err_cnt;
   logic                  o_busy;

   // Line driver side
   modport master (
      output i_bit_en, i_rx,
      input  o_data, o_valid, o_parity_err, o_frame_err, o_err_cnt, o_busy
   );

   // Receiver side
   modport slave (
      input  i_bit_en, i_rx,
      output o_data, o_valid, o_parity_err, o_frame_err, o_err_cnt, o_busy
   );
endinterface

// File: rtl/odd_parity_receiver.sv
// Strobed serial receiver: start, 4 data bits LSB first, odd parity, stop.
module odd_parity_receiver #(
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   odd_parity_receiver_if.slave bus
);
   localparam int unsigned DATA_W = 4;
   localparam int unsigned IDX_W  = 2;
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_W-1:0]     r_d;
   logic                  r_p;
   logic [DATA_W-1:0]     r_data;
   logic                  r_valid;
   logic                  r_perr;
   logic                  r_ferr;
   logic [ERR_CNT_W-1:0]  r_err_cnt;

   state_t                w_state_nxt;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [DATA_W-1:0]     w_d_nxt;
   logic                  w_p_nxt;
   logic [DATA_W-1:0]     w_data_nxt;
   logic                  w_valid_nxt;
   logic                  w_perr_nxt;
   logic                  w_ferr_nxt;
   logic [ERR_CNT_W-1:0]  w_err_cnt_nxt;
   logic                  w_perr_calc;
   logic                  w_ferr_calc;

   // State and result registers; reset wins over any strobe
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_d       <= '0;
         r_p       <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_d       <= w_d_nxt;
         r_p       <= w_p_nxt;
         r_data    <= w_data_nxt;
         r_valid   <= w_valid_nxt;
         r_perr    <= w_perr_nxt;
         r_ferr    <= w_ferr_nxt;
         r_err_cnt <= w_err_cnt_nxt;
      end
   end

   // Next-state and frame decode; nothing moves without a strobe
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_d_nxt       = r_d;
      w_p_nxt       = r_p;
      w_data_nxt    = r_data;
      w_valid_nxt   = 1'b0;
      w_perr_nxt    = r_perr;
      w_ferr_nxt    = r_ferr;
      w_err_cnt_nxt = r_err_cnt;
      w_perr_calc   = ~(^r_d ^ r_p);
      w_ferr_calc   = ~bus.i_rx;

      if (bus.i_bit_en) begin
         case (r_state)
            IDLE: begin
               if (!bus.i_rx) begin
                  w_state_nxt = DATA;
                  w_idx_nxt   = '0;
               end
            end
            DATA: begin
               w_d_nxt[r_idx] = bus.i_rx;
               w_idx_nxt      = r_idx + IDX_W'(1);
               if (r_idx == IDX_W'(DATA_W - 1)) begin
                  w_state_nxt = PARITY;
               end
            end
            PARITY: begin
               w_p_nxt     = bus.i_rx;
               w_state_nxt = STOP;
            end
            STOP: begin
               w_state_nxt = IDLE;
               w_data_nxt  = r_d;
               w_perr_nxt  = w_perr_calc;
               w_ferr_nxt  = w_ferr_calc;
               w_valid_nxt = 1'b1;
               // One increment per bad frame, held at full scale
               if ((w_perr_calc || w_ferr_calc) && (r_err_cnt != CNT_MAX)) begin
                  w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign bus.o_data       = r_data;
   assign bus.o_valid      = r_valid;
   assign bus.o_parity_err = r_perr;
   assign bus.o_frame_err  = r_ferr;
   assign bus.o_err_cnt    = r_err_cnt;
   assign bus.o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_odd_parity_receiver.sv
// Directed bench for odd_parity_receiver: vector table plus reset/saturation sequences.
module tb_odd_parity_receiver;
   logic clk;
   logic rst;

   odd_parity_receiver_if #(.ERR_CNT_W(8)) bus  ();
   odd_parity_receiver_if #(.ERR_CNT_W(2)) bus2 ();

   odd_parity_receiver #(.ERR_CNT_W(8)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   odd_parity_receiver #(.ERR_CNT_W(2)) dut2 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus2)
   );

   assign bus2.i_bit_en = bus.i_bit_en;
   assign bus2.i_rx     = bus.i_rx;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0] d;
      logic       p;
      logic       s;
      int         gap;
      logic [3:0] e_data;
      logic       e_perr;
      logic       e_ferr;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, return just after the rising edge
   task automatic cyc(input logic en, input logic b);
      @(negedge clk);
      bus.i_bit_en = en;
      bus.i_rx     = b;
      @(posedge clk);
      #1;
   endtask

   // Send one frame; gap non-strobe cycles (rx toggling) follow every bit but the stop bit
   task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input int gap);
      logic [6:0] bits;
      bits = {s, p, d, 1'b0};
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, bits[i]);
         if (i < 6) begin
            chk("mid_valid", 32'(bus.o_valid), 32'd0);
            chk("mid_busy", 32'(bus.o_busy), 32'd1);
            for (int g = 0; g < gap; g++) begin
               cyc(1'b0, ~bus.i_rx);
               chk("gap_valid", 32'(bus.o_valid), 32'd0);
               chk("gap_busy", 32'(bus.o_busy), 32'd1);
            end
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
      chk({tag, "_data"}, 32'(bus.o_data), 32'd0);
      chk({tag, "_perr"}, 32'(bus.o_parity_err), 32'd0);
      chk({tag, "_ferr"}, 32'(bus.o_frame_err), 32'd0);
      chk({tag, "_cnt"}, 32'(bus.o_err_cnt), 32'd0);
      chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
   endtask

   task automatic do_reset(input logic en, input logic b);
      @(negedge clk);
      rst          = 1'b1;
      bus.i_bit_en = en;
      bus.i_rx     = b;
      @(posedge clk);
      #1;
      chk_zero("rst");
      chk("rst_cnt2", 32'(bus2.o_err_cnt), 32'd0);
      @(negedge clk);
      rst          = 1'b0;
      bus.i_bit_en = 1'b0;
      bus.i_rx     = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_cnt2;

      vecs[0] = '{d:4'hA, p:1'b1, s:1'b1, gap:0, e_data:4'hA, e_perr:1'b0, e_ferr:1'b0, e_cnt:8'd0};
      vecs[1] = '{d:4'hA, p:1'b0, s:1'b1, gap:0, e_data:4'hA, e_perr:1'b1, e_ferr:1'b0, e_cnt:8'd1};
      vecs[2] = '{d:4'h7, p:1'b0, s:1'b1, gap:0, e_data:4'h7, e_perr:1'b0, e_ferr:1'b0, e_cnt:8'd1};
      vecs[3] = '{d:4'h0, p:1'b1, s:1'b0, gap:0, e_data:4'h0, e_perr:1'b0, e_ferr:1'b1, e_cnt:8'd2};
      vecs[4] = '{d:4'h5, p:1'b1, s:1'b1, gap:0, e_data:4'h5, e_perr:1'b0, e_ferr:1'b0, e_cnt:8'd2};
      vecs[5] = '{d:4'hF, p:1'b0, s:1'b0, gap:0, e_data:4'hF, e_perr:1'b1, e_ferr:1'b1, e_cnt:8'd3};
      vecs[6] = '{d:4'h1, p:1'b0, s:1'b1, gap:0, e_data:4'h1, e_perr:1'b0, e_ferr:1'b0, e_cnt:8'd3};
      vecs[7] = '{d:4'hA, p:1'b1, s:1'b1, gap:2, e_data:4'hA, e_perr:1'b0, e_ferr:1'b0, e_cnt:8'd3};
      vecs[8] = '{d:4'h3, p:1'b0, s:1'b1, gap:2, e_data:4'h3, e_perr:1'b1, e_ferr:1'b0, e_cnt:8'd4};

      rst          = 1'b1;
      bus.i_bit_en = 1'b1;
      bus.i_rx     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("init");
      do_reset(1'b1, 1'b0);

      // Back-to-back frames: each start bit lands on the strobe right after a stop bit
      for (int v = 0; v < 9; v++) begin
         send_frame(vecs[v].d, vecs[v].p, vecs[v].s, vecs[v].gap);
         chk("valid", 32'(bus.o_valid), 32'd1);
         chk("data", 32'(bus.o_data), 32'(vecs[v].e_data));
         chk("perr", 32'(bus.o_parity_err), 32'(vecs[v].e_perr));
         chk("ferr", 32'(bus.o_frame_err), 32'(vecs[v].e_ferr));
         chk("cnt", 32'(bus.o_err_cnt), 32'(vecs[v].e_cnt));
         chk("busy_done", 32'(bus.o_busy), 32'd0);
      end

      // Idle line: valid drops, results hold
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1);
         chk("hold_valid", 32'(bus.o_valid), 32'd0);
         chk("hold_data", 32'(bus.o_data), 32'h3);
         chk("hold_perr", 32'(bus.o_parity_err), 32'd1);
         chk("hold_cnt", 32'(bus.o_err_cnt), 32'd4);
         chk("hold_busy", 32'(bus.o_busy), 32'd0);
      end

      // Reset after d[1] of a partial frame discards it
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      chk("part_busy", 32'(bus.o_busy), 32'd1);
      do_reset(1'b1, 1'b0);
      send_frame(4'hA, 1'b1, 1'b1, 0);
      chk("post_rst_valid", 32'(bus.o_valid), 32'd1);
      chk("post_rst_data", 32'(bus.o_data), 32'hA);
      chk("post_rst_perr", 32'(bus.o_parity_err), 32'd0);
      chk("post_rst_cnt", 32'(bus.o_err_cnt), 32'd0);

      // Saturation: 2-bit counter sticks at 3, 8-bit keeps counting
      do_reset(1'b0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         send_frame(4'hA, 1'b0, 1'b1, 0);
         exp_cnt2 = (k >= 3) ? 2'd3 : 2'(k);
         chk("sat_valid", 32'(bus2.o_valid), 32'd1);
         chk("sat_perr", 32'(bus2.o_parity_err), 32'd1);
         chk("sat_cnt2", 32'(bus2.o_err_cnt), 32'(exp_cnt2));
         chk("sat_cnt8", 32'(bus.o_err_cnt), 32'(k));
      end
      cyc(1'b1, 1'b1);
      chk("sat_tail_valid", 32'(bus2.o_valid), 32'd0);
      chk("sat_tail_cnt2", 32'(bus2.o_err_cnt), 32'd3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/odd_parity_receiver.md
ODD_PARITY_RECEIVER -- requirements
Module: odd_parity_receiver

Interface
REQ-001 Parameter ERR_CNT_W, default 8: width of the saturating error counter; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 bit_en  input  1  bit-sample strobe; rx is sampled only in cycles where bit_en=1.
REQ-005 rx  input  1  serial line; idles high.
REQ-006 data  output  4  last received data nibble, registered.
REQ-007 valid  output  1  one-cycle pulse; a frame has completed.
REQ-008 parity_err  output  1  odd-parity check failed for the frame flagged by valid.
REQ-009 frame_err  output  1  stop bit was sampled low for the frame flagged by valid.
REQ-010 err_cnt  output  ERR_CNT_W  saturating count of frames with parity_err or frame_err.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Frame format: start bit (0), d[0]..d[3] LSB first, one odd-parity bit, one stop bit (1); one bit consumed per bit_en cycle.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP; no transition occurs in any cycle with bit_en=0.
REQ-014 IDLE: bit_en=1 and rx=0 -> DATA with bit index 0; bit_en=1 and rx=1 -> stay IDLE.
REQ-015 DATA: each bit_en cycle stores rx into shift position d[index] and increments index; the bit_en cycle storing d[3] moves to PARITY.
REQ-016 PARITY: bit_en cycle captures rx as p and moves to STOP.
REQ-017 STOP: bit_en cycle moves to IDLE and, on the same clock edge, loads data<=d, parity_err<=~(d[0]^d[1]^d[2]^d[3]^p), frame_err<=~rx, valid<=1.
REQ-018 Latency: valid is high in exactly the cycle following the bit_en cycle that samples the stop bit; low in all other cycles.
REQ-019 data, parity_err, frame_err SHALL hold their values between valid pulses; they update only when valid is set.
REQ-020 A frame with frame_err=1 still returns to IDLE; the next start bit is searched from the following bit_en cycle.
REQ-021 err_cnt increments by exactly 1 on the edge that sets valid when parity_err or frame_err is set for that frame (both set = one increment).
REQ-022 err_cnt saturates at 2^ERR_CNT_W-1 and never wraps.
REQ-023 busy SHALL be combinationally derived from state: 0 in IDLE, 1 in DATA, PARITY, STOP.
REQ-024 Partially received frames SHALL never assert valid nor touch data, flags or err_cnt.

Reset
REQ-025 rst=1 at a rising edge SHALL force state IDLE, bit index 0, data=0, valid=0, parity_err=0, frame_err=0, err_cnt=0, regardless of bit_en or rx that cycle.
REQ-026 rst takes priority over every other event; reset mid-frame discards the partial frame with no valid pulse.
REQ-027 The first bit_en cycle after rst deasserts is treated as an IDLE sample.

Verification
REQ-028 Clean frame, bit_en=1 every cycle, rx=0,0,1,0,1,1,1 (start, d=4'hA, p=1, stop) -> valid one cycle, data=4'hA, parity_err=0, frame_err=0, err_cnt=0.
REQ-029 Same frame with p=0 -> data=4'hA, parity_err=1, frame_err=0, err_cnt=1; then frame d=4'h7,p=0,stop=1 -> parity_err=0, err_cnt stays 1.
REQ-030 Frame d=4'h0,p=1,stop=0 -> frame_err=1, parity_err=0, err_cnt+1; a start bit on the next bit_en cycle is accepted and its frame decodes correctly.
REQ-031 bit_en high only every 3rd cycle with rx toggling between strobes -> same results as REQ-028; no transition on non-strobe cycles; busy high from start sample until valid.
REQ-032 rst=1 asserted after d[1] of a frame -> no valid pulse, outputs zero, busy=0; a following full frame decodes correctly.
REQ-033 ERR_CNT_W=2, five consecutive parity-error frames -> err_cnt=1,2,3,3,3.
